// File: rtl/wb_port_arbiter.sv
// Write-port arbiter between the W stage and a buffered long-latency result unit.
// Define WB_PORT_ARB_STARVE_EN to add the starvation counter that forces a FIFO drain.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        w_we,
    input  logic [4:0]  w_addr,
    input  logic [31:0] w_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  q_addr,
    output logic        q_hit
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [4:0]       fifo_addr [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [PTR_W-1:0] offs [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] w_match;
    logic [DEPTH-1:0] q_match;

    logic empty;
    logic w_slot;
    logic hit;
    logic force_drain;
    logic pop;
    logic push;
    logic bypass;

    assign empty  = (count == '0);
    assign w_slot = w_we && (w_addr != 5'd0);

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        entry_valid = '0;
        w_match     = '0;
        q_match     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs[i]        = PTR_W'(i) - rd_ptr;
            entry_valid[i] = (CNT_W'(offs[i]) < count);
            w_match[i]     = entry_valid[i] && (fifo_addr[i] == w_addr);
            q_match[i]     = entry_valid[i] && (fifo_addr[i] == q_addr);
        end
    end

    assign hit        = w_slot && (|w_match);
    assign q_hit      = (q_addr != 5'd0) && (|q_match);
    assign pipe_stall = !empty && (hit || force_drain);
    assign lu_ready   = reset && (count < CNT_W'(DEPTH));

`ifdef WB_PORT_ARB_STARVE_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    logic [SC_W-1:0] starve_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (pop || empty) begin
            starve_cnt <= '0;
        end else if (starve_cnt < SC_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    assign force_drain = (starve_cnt >= SC_W'(STARVE_LIMIT));
`else
    assign force_drain = 1'b0;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pop      = 1'b0;
        bypass   = 1'b0;
        rf_we    = 1'b0;
        rf_addr  = w_addr;
        rf_wdata = w_data;
        if (!reset) begin
            rf_we = 1'b0;
        end else if (!empty && (!w_slot || pipe_stall)) begin
            pop      = 1'b1;
            rf_we    = 1'b1;
            rf_addr  = fifo_addr[rd_ptr];
            rf_wdata = fifo_data[rd_ptr];
        end else if (w_slot) begin
            rf_we = 1'b1;
        end else if (empty && lu_valid && (lu_addr != 5'd0)) begin
            bypass   = 1'b1;
            rf_we    = 1'b1;
            rf_addr  = lu_addr;
            rf_wdata = lu_data;
        end
    end

    // Results to $0 are accepted and dropped; bypassed results never occupy a slot.
    assign push = lu_valid && lu_ready && (lu_addr != 5'd0) && !bypass;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // NOTE: storage is not reset; validity is derived from count, which is.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= lu_addr;
            fifo_data[wr_ptr] <= lu_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: queue-based reference model plus directed literal checks.
module tb_wb_port_arbiter;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        w_we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [4:0]  q_addr;
    logic        q_hit;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
        .pipe_stall(pipe_stall),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .q_addr(q_addr), .q_hit(q_hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    // Reference model: pending results in age order, plus cycles waited since the last pop.
    entry_t q[$];
    int     starve = 0;
    int     n_tests = 0;
    int     n_fail  = 0;

    logic        e_we, e_stall, e_ready, e_qhit;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_pop, e_push;
    entry_t      e_ent;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic bit in_q(input logic [4:0] a);
        foreach (q[i]) if (q[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic [4:0] qa);
        w_we = we; w_addr = wa; w_data = wd;
        lu_valid = lv; lu_addr = la; lu_data = ld;
        q_addr = qa;
    endtask

    // Settle to mid-cycle, derive what the outputs must be, compare every output.
    task automatic eval_cycle();
        bit w_slot, hit, frc;
        #4;
        e_we = 1'b0; e_addr = '0; e_data = '0; e_pop = 1'b0; e_push = 1'b0;
        e_stall = 1'b0; e_ready = 1'b0; e_qhit = 1'b0;
        if (reset) begin
            w_slot = w_we && (w_addr != 0);
            hit    = w_slot && in_q(w_addr);
`ifdef WB_PORT_ARB_STARVE_EN
            frc = (starve >= STARVE_LIMIT);
`else
            frc = 1'b0;
`endif
            e_stall = (q.size() != 0) && (hit || frc);
            e_ready = (q.size() < DEPTH);
            e_qhit  = (q_addr != 0) && in_q(q_addr);
            if ((q.size() != 0) && (!w_slot || e_stall)) begin
                e_we = 1'b1; e_addr = q[0].addr; e_data = q[0].data; e_pop = 1'b1;
            end else if (w_slot) begin
                e_we = 1'b1; e_addr = w_addr; e_data = w_data;
            end else if ((q.size() == 0) && lu_valid && (lu_addr != 0)) begin
                e_we = 1'b1; e_addr = lu_addr; e_data = lu_data;
            end
            e_push = lu_valid && e_ready && (lu_addr != 0) &&
                     !((q.size() == 0) && !w_slot && e_we);
            e_ent.addr = lu_addr;
            e_ent.data = lu_data;
        end
        check("rf_we", rf_we, e_we);
        check("pipe_stall", pipe_stall, e_stall);
        check("lu_ready", lu_ready, e_ready);
        check("q_hit", q_hit, e_qhit);
        if (e_we) begin
            check("rf_addr", rf_addr, e_addr);
            check("rf_wdata", rf_wdata, e_data);
        end
    endtask

    task automatic tick();
        bit was_empty;
        @(posedge clk);
        if (!reset) begin
            q.delete();
            starve = 0;
        end else begin
            was_empty = (q.size() == 0);
            if (e_pop) void'(q.pop_front());
            if (e_push) q.push_back(e_ent);
            if (e_pop || was_empty) starve = 0;
            else if (starve < STARVE_LIMIT) starve++;
        end
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 5'd4);
        tick();

        // Reset state with live inputs: everything held low.
        eval_cycle();
        check("reset_rf_we", rf_we, 0);
        check("reset_lu_ready", lu_ready, 0);
        tick();

        // Bypass into an empty FIFO with an idle W slot.
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5);
        eval_cycle();
        check("bypass_we", rf_we, 1);
        check("bypass_addr", rf_addr, 5);
        check("bypass_data", rf_wdata, 32'hDEADBEEF);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5);
        eval_cycle();
        check("bypass_not_queued", q_hit, 0);
        check("bypass_ready", lu_ready, 1);
        tick();

        // Queue two results behind a busy W stage, then drain them in order.
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h7777_0007, 5'd0);
        eval_cycle();
        check("qd_w_addr0", rf_addr, 3);
        tick();
        drive(1'b1, 5'd3, 32'h34, 1'b1, 5'd8, 32'h8888_0008, 5'd7);
        eval_cycle();
        check("qd_w_addr1", rf_addr, 3);
        check("qd_qhit7", q_hit, 1);
        tick();
        drive(1'b1, 5'd3, 32'h35, 1'b0, 5'd0, 32'h0, 5'd8);
        eval_cycle();
        check("qd_full_ready", lu_ready, 0);
        check("qd_no_stall", pipe_stall, 0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
        eval_cycle();
        check("qd_drain7_addr", rf_addr, 7);
        check("qd_drain7_data", rf_wdata, 32'h7777_0007);
        tick();
        eval_cycle();
        check("qd_drain8_addr", rf_addr, 8);
        check("qd_drain8_ready", lu_ready, 1);
        tick();
        eval_cycle();
        check("qd_idle_we", rf_we, 0);
        tick();

        // WAW: older queued value for $9 must land before the W write.
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h99, 5'd9);
        eval_cycle();
        tick();
        drive(1'b1, 5'd9, 32'h11, 1'b0, 5'd0, 32'h0, 5'd9);
        eval_cycle();
        check("waw_stall", pipe_stall, 1);
        check("waw_fifo_addr", rf_addr, 9);
        check("waw_fifo_data", rf_wdata, 32'h99);
        tick();
        eval_cycle();
        check("waw_release", pipe_stall, 0);
        check("waw_w_data", rf_wdata, 32'h11);
        tick();

        // $0 handling for lu results, the W slot and the query port.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBAD, 5'd0);
        eval_cycle();
        check("zero_lu_no_write", rf_we, 0);
        check("zero_lu_ready", lu_ready, 1);
        tick();
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66, 5'd6);
        eval_cycle();
        tick();
        drive(1'b1, 5'd2, 32'h23, 1'b0, 5'd0, 32'h0, 5'd6);
        eval_cycle();
        check("zero_qhit6", q_hit, 1);
        tick();
        drive(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
        eval_cycle();
        check("zero_w_drains", rf_addr, 6);
        check("zero_qaddr", q_hit, 0);
        tick();

        // Starvation: one entry waiting behind a continuously busy W stage.
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd10, 32'hA0, 5'd0);
        eval_cycle();
        tick();
        drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0, 5'd0);
        for (int k = 1; k <= 10; k++) begin
            eval_cycle();
`ifdef WB_PORT_ARB_STARVE_EN
            check($sformatf("starve_stall_%0d", k), pipe_stall, (k == 9) ? 1 : 0);
            check($sformatf("starve_addr_%0d", k), rf_addr, (k == 9) ? 10 : 4);
`else
            check($sformatf("nostarve_stall_%0d", k), pipe_stall, 0);
            check($sformatf("nostarve_addr_%0d", k), rf_addr, 4);
`endif
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
        eval_cycle();
        tick();

        // Asynchronous reset in the middle of a WAW stall.
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd12, 32'hC0, 5'd12);
        eval_cycle();
        tick();
        drive(1'b1, 5'd12, 32'h12, 1'b0, 5'd0, 32'h0, 5'd12);
        eval_cycle();
        check("arst_pre_stall", pipe_stall, 1);
        #1 reset = 1'b0;
        #1;
        check("arst_stall", pipe_stall, 0);
        check("arst_rf_we", rf_we, 0);
        check("arst_ready", lu_ready, 0);
        check("arst_qhit", q_hit, 0);
        tick();
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd12);
        eval_cycle();
        check("arst_after_ready", lu_ready, 1);
        check("arst_after_empty", q_hit, 0);
        tick();

        // Randomized traffic on a small address range to provoke hits and backpressure.
        for (int n = 0; n < 4000; n++) begin
            if (!e_stall) begin
                w_we   = ($urandom_range(0, 3) != 0);
                w_addr = 5'($urandom_range(0, 7));
                w_data = $urandom;
            end
            lu_valid = ($urandom_range(0, 2) == 0);
            lu_addr  = 5'($urandom_range(0, 7));
            lu_data  = $urandom;
            q_addr   = 5'($urandom_range(0, 7));
            reset    = ($urandom_range(0, 499) != 0);
            eval_cycle();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
